vec_checker: RTL and testbench
==============================

# vec_checker

Response-checking block for generated testbenches. Expected output vectors, with per-bit don't-care masks, are queued in a small FIFO. Each observed DUT output sample is compared against the oldest queued vector, and the block keeps mismatch and vector statistics. It is the reading end of the vector stream, the counterpart of the stimulus side that drives DUT inputs, and it sits between the DUT output bus and the bench's pass/fail reporting.

## Interface
- `WIDTH`, default 32: width of the compared DUT output bus.
- `DEPTH`, default 8: expected-vector FIFO entries; power of two, at least 2.
- `TIMEOUT`, default 64: maximum cycles spent in DRAIN waiting for outstanding observations.

- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: one-cycle pulse; clears statistics and enters RUN.
- `exp_valid`, input, 1: expected vector offered.
- `exp_ready`, output, 1: FIFO can accept; high when not full and the state is RUN.
- `exp_data`, input, WIDTH: expected value.
- `exp_mask`, input, WIDTH: 1 means compare the bit, 0 means don't care.
- `obs_valid`, input, 1: DUT output sample valid this cycle; no backpressure.
- `obs_data`, input, WIDTH: observed DUT outputs.
- `end_test`, input, 1: one-cycle pulse; the stimulus side has finished.
- `done`, output, 1: level, high in DONE.
- `pass`, output, 1: valid when `done`; high when `err_cnt == 0`.
- `err_cnt`, output, 16: saturating error count.
- `vec_cnt`, output, 16: saturating count of observations compared.
- `underrun`, output, 1: sticky; an observation arrived with the FIFO empty.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE to RUN on `start`. DONE to RUN on `start`. `start` in RUN or DRAIN restarts: the FIFO is flushed, all counters and flags are cleared, and the state is RUN.
- RUN:
  - A push occurs on `exp_valid && exp_ready`.
  - On `obs_valid` with the FIFO non-empty, pop the head, compute `((obs_data ^ head_data) & head_mask) != 0`, and increment `vec_cnt`. A mismatch increments `err_cnt`.
  - On `obs_valid` with the FIFO empty, increment `err_cnt`, set `underrun`, and leave `vec_cnt` unchanged.
  - A push and pop in the same cycle are both performed and occupancy is unchanged. With the FIFO full, a pop frees the slot in that cycle, but `exp_ready` is registered from the pre-pop occupancy, so the push waits one cycle.
- `end_test` in RUN goes to DONE if the FIFO is empty, otherwise to DRAIN and loads the timeout counter with `TIMEOUT`. `end_test` outside RUN is ignored.
- DRAIN:
  - No pushes; `exp_ready` is 0. Observations are processed as in RUN.
  - The FIFO becoming empty goes to DONE.
  - The timeout counter reaching 0 goes to DONE. Each remaining entry adds 1 to `err_cnt`, saturating, and the FIFO is flushed.
- DONE:
  - Counters are frozen.
  - `obs_valid` is ignored.
  - `pass = (err_cnt == 0)`.
- Counter arithmetic:
  - 16-bit, saturating at 16'hFFFF, never wrapping.
  - The leftover-entry addition is a single saturating add of the occupancy.
- FIFO pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal; wrap-around is natural.

## Timing
- Reset values:
  - `exp_ready` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `vec_cnt` = 0, `underrun` = 0.
  - FIFO empty, state IDLE.
- Compare latency: `err_cnt` and `vec_cnt` reflect an observation sampled at edge N after edge N+1, one cycle of registered compare.
- `exp_ready` is registered. A push is accepted on the edge where both `exp_valid` and `exp_ready` are high.
- `done` rises one cycle after the DRAIN or RUN exit condition is sampled. `pass` is valid in the same cycle as `done`.
- Asynchronous reset mid-operation immediately forces all outputs to their reset values and discards FIFO contents.

## Configuration
- `VEC_CHECKER_FIRST_ERR_EN`, when defined:
  - Adds outputs `first_err_idx` (16) and `first_err_obs` (WIDTH), plus sticky `first_err_vld`.
  - These latch `vec_cnt` and `obs_data` of the first mismatch or underrun after `start`. They are cleared on reset and on `start`, and later errors do not overwrite them.
- When undefined, these ports and registers are absent and the remaining behaviour is identical.

## Test plan
- Reset, `start`, then push 4 vectors with mask all ones. Feed 4 identical observations, then `end_test`: `vec_cnt` = 4, `err_cnt` = 0, `done` = 1, `pass` = 1.
- Push expected 32'hA5A5_0000 with mask 32'hFFFF_0000 and observe 32'hA5A5_FFFF, which is a pass. Then push 32'h1 with mask 32'h1 and observe 32'h0: `err_cnt` = 1, `pass` = 0. With `VEC_CHECKER_FIRST_ERR_EN`: `first_err_idx` = 1, `first_err_obs` = 32'h0.
- Fill 8 entries: `exp_ready` drops. Then push and observe on the same cycle repeatedly for 20 cycles: occupancy steady, no lost vectors, `err_cnt` = 0.
- `obs_valid` with the FIFO empty in RUN: `underrun` = 1, `err_cnt` = 1, `vec_cnt` unchanged.
- 3 entries queued, then `end_test` and no observations: DRAIN for 64 cycles, then `done`, `err_cnt` = 3. Repeat with 1 observation arriving in DRAIN: `err_cnt` = 2.
- Drive `err_cnt` to 16'hFFFF through repeated underruns: it stays at 16'hFFFF. Assert `rst_n` low mid-RUN: all outputs return to 0 asynchronously, and the state is IDLE.

Source files
------------

// File: rtl/vec_checker.sv
// vec_checker: response checker for generated benches.
// Expected vectors with per-bit compare masks are queued in a small FIFO.
// Each observed DUT sample is compared against the oldest queued vector,
// and mismatch, vector and underrun statistics are kept.
//
// Parameters: WIDTH (compared bus width), DEPTH (FIFO entries, power of two,
//   >= 2), TIMEOUT (max cycles spent in DRAIN).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   pulse: flush, clear stats, enter RUN
//   exp_valid/ready/data/mask  expected-vector push side (mask 1 = compare)
//   obs_valid/obs_data      observed DUT sample, no backpressure
//   end_test                pulse: stimulus finished
//   done, pass              done is level in DONE; pass = done && err_cnt==0
//   err_cnt, vec_cnt        16-bit saturating statistics
//   underrun                sticky: observation arrived with FIFO empty
// Optional feature macro VEC_CHECKER_FIRST_ERR_EN adds first_err_idx,
//   first_err_obs, first_err_vld capturing the first mismatch/underrun.
module vec_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] exp_mask,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_data,
  input  logic             end_test,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic [15:0]      vec_cnt,
  output logic             underrun
`ifdef VEC_CHECKER_FIRST_ERR_EN
  ,
  output logic [15:0]      first_err_idx,
  output logic [WIDTH-1:0] first_err_obs,
  output logic             first_err_vld
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [WIDTH-1:0] mem_mask [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, occ, occ_nx, leftover;
  logic [AW+1:0]    err_add;
  logic [TW-1:0]    tmo;
  logic             empty, active, push, pop, obs_take, mis, flush, tmo_hit;
  // registered compare stage: one cycle between sampling and counting
  logic             p_vld, p_hit, p_mis;
  logic [WIDTH-1:0] p_obs;

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // occupancy from the extra pointer MSB; wraps naturally
  assign occ      = wr_ptr - rd_ptr;
  assign empty    = (occ == '0);
  assign active   = (state == RUN) || (state == DRAIN);
  assign push     = exp_valid && exp_ready && !start;
  assign obs_take = obs_valid && active && !start;
  assign pop      = obs_take && !empty;
  assign mis      = ((obs_data ^ mem_data[rd_ptr[AW-1:0]]) & mem_mask[rd_ptr[AW-1:0]]) != '0;
  assign occ_nx   = occ + (push ? ONE : '0) - (pop ? ONE : '0);
  assign tmo_hit  = (tmo <= TW'(1));
  // entries still queued at timeout each count as one error
  assign leftover = flush ? (occ - (pop ? ONE : '0)) : '0;
  assign err_add  = {1'b0, leftover} + {{(AW+1){1'b0}}, p_vld & p_mis};

  assign done = (state == DONE);
  assign pass = done && (err_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    flush    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (start) state_nx = RUN;
             else if (end_test) state_nx = (occ_nx == '0) ? DONE : DRAIN;
      DRAIN: if (start) state_nx = RUN;
             else if (empty) state_nx = DONE;
             else if (tmo_hit) begin
               state_nx = DONE;
               flush    = 1'b1;
             end
      DONE:  if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= exp_data;
      mem_mask[wr_ptr[AW-1:0]] <= exp_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      p_vld     <= 1'b0;
      p_hit     <= 1'b0;
      p_mis     <= 1'b0;
      p_obs     <= '0;
      err_cnt   <= '0;
      vec_cnt   <= '0;
      underrun  <= 1'b0;
      tmo       <= '0;
      exp_ready <= 1'b0;
    end else if (start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      p_vld     <= 1'b0;
      p_hit     <= 1'b0;
      p_mis     <= 1'b0;
      p_obs     <= '0;
      err_cnt   <= '0;
      vec_cnt   <= '0;
      underrun  <= 1'b0;
      tmo       <= '0;
      exp_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + ONE;
      p_vld <= obs_take;
      p_hit <= pop;
      p_mis <= pop ? mis : 1'b1;  // an underrun counts as an error
      p_obs <= obs_data;
      err_cnt <= sat16(err_cnt, 16'(err_add));
      vec_cnt <= sat16(vec_cnt, {15'd0, p_vld & p_hit});
      if (p_vld && !p_hit) underrun <= 1'b1;
      if (state == RUN && state_nx == DRAIN) tmo <= TW'(TIMEOUT);
      else if (state == DRAIN && tmo != '0) tmo <= tmo - TW'(1);
      // ready reflects occupancy after this edge, so a full FIFO freed by
      // a pop accepts the next push one cycle later
      exp_ready <= (state_nx == RUN) && (occ_nx != (AW+1)'(DEPTH));
    end
  end

`ifdef VEC_CHECKER_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_idx <= '0;
      first_err_obs <= '0;
      first_err_vld <= 1'b0;
    end else if (start) begin
      first_err_idx <= '0;
      first_err_obs <= '0;
      first_err_vld <= 1'b0;
    end else if (p_vld && p_mis && !first_err_vld) begin
      // vec_cnt here still excludes the erroring observation
      first_err_idx <= vec_cnt;
      first_err_obs <= p_obs;
      first_err_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_checker.sv
// Bench for vec_checker: queue-based behavioural model compared every cycle,
// randomized traffic, plus literal expectations for the directed scenarios.
module tb_vec_checker;
  localparam int W = 32, D = 8, TMO = 64;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, exp_valid = 1'b0, obs_valid = 1'b0, end_test = 1'b0;
  logic [W-1:0] exp_data = '0, exp_mask = '0, obs_data = '0;
  logic         exp_ready, done, pass, underrun;
  logic [15:0]  err_cnt, vec_cnt;
`ifdef VEC_CHECKER_FIRST_ERR_EN
  logic [15:0]  first_err_idx;
  logic [W-1:0] first_err_obs;
  logic         first_err_vld;
`endif

  always #5 clk = ~clk;

  vec_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data), .exp_mask(exp_mask),
    .obs_valid(obs_valid), .obs_data(obs_data), .end_test(end_test),
    .done(done), .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt), .underrun(underrun)
`ifdef VEC_CHECKER_FIRST_ERR_EN
    , .first_err_idx(first_err_idx), .first_err_obs(first_err_obs), .first_err_vld(first_err_vld)
`endif
  );

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [W-1:0] d; logic [W-1:0] m; } ev_t;
  ev_t          mq[$];
  int           mst = 0;            // 0 idle, 1 run, 2 drain, 3 done
  int           m_err = 0, m_vec = 0, drain_left = 0, fe_idx = 0;
  bit           m_und = 0, m_rdy = 0, fe_vld = 0;
  bit           pend = 0, pend_hit = 0, pend_err = 0;
  logic [W-1:0] pend_obs = '0, fe_obs = '0;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit o_pend, o_hit, o_err;
    logic [W-1:0] o_obs;
    int occ0, add_e, add_v;
    ev_t e;
    if (!rst_n || start) begin
      mq.delete();
      mst = rst_n ? 1 : 0;
      m_rdy = rst_n;
      m_err = 0; m_vec = 0; m_und = 0; drain_left = 0;
      pend = 0; pend_hit = 0; pend_err = 0; pend_obs = '0;
      fe_vld = 0; fe_idx = 0; fe_obs = '0;
    end else begin
      o_pend = pend; o_hit = pend_hit; o_err = pend_err; o_obs = pend_obs;
      occ0  = mq.size();
      add_e = (o_pend && o_err) ? 1 : 0;
      add_v = (o_pend && o_hit) ? 1 : 0;
      if (o_pend && o_err && !fe_vld) begin
        fe_vld = 1; fe_idx = m_vec; fe_obs = o_obs;
      end
      pend = (mst == 1 || mst == 2) && obs_valid;
      pend_hit = 0; pend_err = 0; pend_obs = obs_data;
      if (pend) begin
        if (occ0 > 0) begin
          e = mq.pop_front();
          pend_hit = 1;
          pend_err = (((obs_data ^ e.d) & e.m) != '0);
        end else pend_err = 1;
      end
      if (m_rdy && exp_valid) begin
        e.d = exp_data; e.m = exp_mask;
        mq.push_back(e);
      end
      if (mst == 1) begin
        if (end_test) begin
          if (mq.size() == 0) mst = 3;
          else begin mst = 2; drain_left = TMO; end
        end
      end else if (mst == 2) begin
        if (occ0 == 0) mst = 3;
        else begin
          drain_left--;
          if (drain_left == 0) begin
            add_e += mq.size();
            mq.delete();
            mst = 3;
          end
        end
      end
      m_err = sat(m_err + add_e);
      m_vec = sat(m_vec + add_v);
      if (o_pend && !o_hit) m_und = 1;
      m_rdy = (mst == 1) && (mq.size() < D);
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("exp_ready", exp_ready, m_rdy);
      chk("done", done, mst == 3);
      chk("pass", pass, (mst == 3) && (m_err == 0));
      chk("err_cnt", err_cnt, m_err);
      chk("vec_cnt", vec_cnt, m_vec);
      chk("underrun", underrun, m_und);
`ifdef VEC_CHECKER_FIRST_ERR_EN
      chk("first_err_vld", first_err_vld, fe_vld);
      if (fe_vld) begin
        chk("first_err_idx", first_err_idx, fe_idx);
        chk("first_err_obs", first_err_obs, fe_obs);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] sq[$];   // data of accepted vectors, oldest first

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    sq.delete();
  endtask

  task automatic do_end();
    end_test = 1'b1; tick(); end_test = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [W-1:0] m);
    bit acc = 0;
    exp_valid = 1'b1; exp_data = d; exp_mask = m;
    for (int k = 0; k < 32 && !acc; k++) begin
      acc = exp_ready;
      tick();
    end
    exp_valid = 1'b0;
    if (acc) sq.push_back(d);
    else chk("push_accept", 0, 1);
  endtask

  task automatic obs(input logic [W-1:0] d);
    obs_valid = 1'b1; obs_data = d; tick(); obs_valid = 1'b0;
    if (sq.size() > 0) void'(sq.pop_front());
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 300) begin tick(); n++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    bit acc;
    logic [W-1:0] d;
    // reset state
    tick(); tick();
    chk("rst_exp_ready", exp_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_vec", vec_cnt, 0);
    chk("rst_underrun", underrun, 0);
    cmp_en = 1;
    rst_n = 1'b1;
    tick();

    // four matching vectors
    do_start();
    for (int i = 0; i < 4; i++) push($urandom, '1);
    for (int i = 0; i < 4; i++) obs(sq[0]);
    do_end(); tick();
    chk("t1_vec", vec_cnt, 4);
    chk("t1_err", err_cnt, 0);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);

    // masked pass, then single-bit mismatch
    do_start();
    push(32'hA5A5_0000, 32'hFFFF_0000);
    obs(32'hA5A5_FFFF);
    push(32'h1, 32'h1);
    obs(32'h0);
    do_end(); tick();
    chk("t2_err", err_cnt, 1);
    chk("t2_pass", pass, 0);
    chk("t2_vec", vec_cnt, 2);
`ifdef VEC_CHECKER_FIRST_ERR_EN
    chk("t2_fe_idx", first_err_idx, 1);
    chk("t2_fe_obs", first_err_obs, 0);
`endif

    // fill, then concurrent push/observe
    do_start();
    for (int i = 0; i < D; i++) push($urandom, $urandom);
    chk("t3_full_ready", exp_ready, 0);
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      exp_valid = 1'b1; exp_data = d; exp_mask = '1;
      obs_valid = 1'b1; obs_data = sq[0];
      acc = exp_ready;
      void'(sq.pop_front());
      tick();
      if (acc) sq.push_back(d);
    end
    exp_valid = 1'b0; obs_valid = 1'b0;
    chk("t3_ready_steady", exp_ready, 1);
    while (sq.size() > 0) obs(sq[0]);
    do_end(); tick();
    chk("t3_err", err_cnt, 0);
    chk("t3_vec", vec_cnt, 27);

    // underrun
    do_start();
    obs_valid = 1'b1; obs_data = $urandom; tick(); obs_valid = 1'b0;
    tick();
    chk("t4_underrun", underrun, 1);
    chk("t4_err", err_cnt, 1);
    chk("t4_vec", vec_cnt, 0);

    // drain timeout with three leftovers
    do_start();
    for (int i = 0; i < 3; i++) push($urandom, '1);
    do_end();
    wait_done(n);
    chk("t5_drain_cycles", n, TMO);
    chk("t5_err", err_cnt, 3);
    // one observation during DRAIN
    do_start();
    for (int i = 0; i < 3; i++) push($urandom, '1);
    do_end();
    obs(sq[0]);
    wait_done(n);
    chk("t5b_err", err_cnt, 2);
    chk("t5b_vec", vec_cnt, 1);

    // randomized traffic
    for (int r = 0; r < 3; r++) begin
      do_start();
      for (int i = 0; i < 400; i++) begin
        d = $urandom;
        exp_valid = $urandom_range(0, 1); exp_data = d; exp_mask = $urandom;
        obs_valid = ($urandom_range(0, 2) == 0);
        if (sq.size() > 0 && $urandom_range(0, 3) != 0)
          obs_data = sq[0] ^ ($urandom_range(0, 1) ? 32'h0 : 32'($urandom));
        else obs_data = $urandom;
        acc = exp_valid && exp_ready;
        if (obs_valid && sq.size() > 0) void'(sq.pop_front());
        tick();
        if (acc) sq.push_back(d);
      end
      exp_valid = 1'b0; obs_valid = 1'b0;
      do_end();
      wait_done(n);
    end

    // saturation through repeated underruns
    do_start();
    obs_valid = 1'b1; obs_data = $urandom;
    repeat (65540) tick();
    chk("t7_err_sat", err_cnt, 16'hFFFF);
    repeat (5) tick();
    obs_valid = 1'b0;
    chk("t7_err_hold", err_cnt, 16'hFFFF);
    chk("t7_underrun", underrun, 1);
    chk("t7_vec", vec_cnt, 0);

    // asynchronous reset mid-RUN
    push($urandom, '1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_exp_ready", exp_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_vec", vec_cnt, 0);
    chk("arst_underrun", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sq.delete();
    exp_valid = 1'b1; exp_data = $urandom; exp_mask = '1;
    obs_valid = 1'b1; obs_data = $urandom;
    tick(); tick();
    exp_valid = 1'b0; obs_valid = 1'b0;
    chk("idle_ready", exp_ready, 0);
    chk("idle_vec", vec_cnt, 0);
    chk("idle_underrun", underrun, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
